fetch_seq: RTL and testbench

Instruction-fetch sequencer driving the dual-ROM instruction memory mux (combinational read, byte address, sel chooses rom1/rom2). Owns the PC and the bank-select line, and presents one registered instruction per cycle to decode over a valid/ready handshake. Handles branch redirects and safe ROM-bank switching (drain, switch, restart at RESET_PC), and latches a sticky fault on misaligned or out-of-range fetch.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_perf_cnt.sv | 43 ++++
 rtl/fetch_seq.sv | 173 +++++++++++++++++
 tb/tb_fetch_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch sequencer.
//   fetch_state_e    : sequencer FSM states (RUN, DRAIN, SWITCH, FAULT)
//   RESET_PC_DEFAULT : default restart PC after reset and after a bank switch
//   PC_INC           : byte increment between consecutive instruction words
//   fetchPcBad()     : flags a byte address that is misaligned or beyond the ROM
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    FAULT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // A fetch address is bad if it is not word aligned or if its word index
  // falls outside a ROM of 2^addrWidth words.
  function automatic logic fetchPcBad(input logic [31:0] pc, input int unsigned addrWidth);
    logic [32:0] depth;
    depth = 33'd1 << addrWidth;
    return (pc[1:0] != 2'b00) || ({3'b000, pc[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: pair of saturating 32-bit event counters for fetch activity.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset, clears both counters
//   fetchInc_i     : count one instruction capture this cycle
//   stallInc_i     : count one stalled RUN cycle
//   fetchCnt_o     : captures since reset, saturates at all-ones
//   stallCnt_o     : stalled RUN cycles since reset, saturates at all-ones
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetchInc_i,
  input  logic        stallInc_i,
  output logic [31:0] fetchCnt_o,
  output logic [31:0] stallCnt_o
);

  logic [31:0] fetchCnt_q, fetchCnt_d;
  logic [31:0] stallCnt_q, stallCnt_d;

  // Counters stop at all-ones instead of wrapping so a long run never
  // reports a misleadingly small value.
  always_comb begin
    fetchCnt_d = fetchCnt_q;
    stallCnt_d = stallCnt_q;
    if (fetchInc_i && (fetchCnt_q != 32'hFFFF_FFFF)) fetchCnt_d = fetchCnt_q + 32'd1;
    if (stallInc_i && (stallCnt_q != 32'hFFFF_FFFF)) stallCnt_d = stallCnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCnt_q <= 32'd0;
      stallCnt_q <= 32'd0;
    end else begin
      fetchCnt_q <= fetchCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign fetchCnt_o = fetchCnt_q;
  assign stallCnt_o = stallCnt_q;

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer in front of a dual-ROM memory mux.
// Owns the PC and bank select, hands one registered instruction per cycle to
// decode over valid/ready, handles branch redirects, drains and switches ROM
// banks safely, and latches a sticky fault on a bad fetch address.
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
// Ports:
//   clk, rst_n                   : clock (rising edge), async active-low reset
//   stall                        : hold PC and capture
//   redirect_valid, redirect_pc  : branch/jump target (byte address)
//   bank_switch, bank_req        : one-cycle request to move to ROM bank bank_req
//   imem_addr, imem_sel          : address and bank select to instruction memory
//   imem_instr                   : combinational read data from memory
//   out_valid, out_ready         : handshake to decode
//   out_instr, out_pc            : registered instruction and its address
//   bank_busy                    : bank switch in progress (DRAIN or SWITCH)
//   perf_fetch_cnt, perf_stall_cnt (FETCH_PERF_EN only) : activity counters
//   fault                        : sticky fetch fault
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  bank_switch,
  input  logic                  bank_req,
  output logic [31:0]           imem_addr,
  output logic                  imem_sel,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc,
  output logic                  bank_busy,
`ifdef FETCH_PERF_EN
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  fault
);

  // Byte address of the final ROM word; fetching it ends the program.
  localparam logic [31:0] LAST_PC = 32'(((64'd1 << ADDR_WIDTH) - 64'd1) << 2);

  fetch_state_e          state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  sel_q, sel_d;
  logic                  bankLatch_q, bankLatch_d;
  logic                  outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0] outInstr_q, outInstr_d;
  logic [31:0]           outPc_q, outPc_d;
  logic                  fault_q, fault_d;

  logic accept;
  logic switchReq;
  logic captureEn;

  assign accept    = outValid_q && out_ready;
  assign switchReq = bank_switch && (bank_req != sel_q);
  // A capture only happens in RUN when neither a real bank switch nor a
  // redirect claims the cycle, and the output slot is free or being emptied.
  assign captureEn = (state_q == RUN) && !switchReq && !redirect_valid &&
                     !stall && (!outValid_q || out_ready);

  // Next-state and datapath decisions. A redirect always leaves out_valid
  // low: either the held word is squashed or it is accepted this cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sel_d       = sel_q;
    bankLatch_d = bankLatch_q;
    outValid_d  = outValid_q;
    outInstr_d  = outInstr_q;
    outPc_d     = outPc_q;
    fault_d     = fault_q;

    case (state_q)
      RUN: begin
        if (switchReq) begin
          bankLatch_d = bank_req;
          state_d     = DRAIN;
          if (accept) outValid_d = 1'b0;
        end else if (redirect_valid) begin
          outValid_d = 1'b0;
          if (fetchPcBad(redirect_pc, ADDR_WIDTH)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (captureEn) begin
          outInstr_d = imem_instr;
          outPc_d    = pc_q;
          outValid_d = 1'b1;
          // The last word is still delivered, but the PC never wraps to 0.
          if (pc_q == LAST_PC) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end else if (accept) begin
          outValid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (accept) outValid_d = 1'b0;
        if (!outValid_q) state_d = SWITCH;
      end

      SWITCH: begin
        sel_d   = bankLatch_q;
        pc_d    = RESET_PC;
        state_d = RUN;
      end

      FAULT: begin
        fault_d = 1'b1;
        if (accept) outValid_d = 1'b0;
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      sel_q       <= 1'b0;
      bankLatch_q <= 1'b0;
      outValid_q  <= 1'b0;
      outInstr_q  <= '0;
      outPc_q     <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sel_q       <= sel_d;
      bankLatch_q <= bankLatch_d;
      outValid_q  <= outValid_d;
      outInstr_q  <= outInstr_d;
      outPc_q     <= outPc_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_sel  = sel_q;
  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_pc    = outPc_q;
  assign bank_busy = (state_q == DRAIN) || (state_q == SWITCH);
  assign fault     = fault_q;

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetchInc_i (captureEn),
    .stallInc_i ((state_q == RUN) && stall),
    .fetchCnt_o (perf_fetch_cnt),
    .stallCnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq with a behavioural
// dual-ROM. rom1 word i holds 32'hA000_0000+i, rom2 word i holds 32'hB000_0000+i.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bank_switch;
  logic        bank_req;
  logic [31:0] imem_addr;
  logic        imem_sel;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        bank_busy;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] rom1 [0:1023];
  logic [31:0] rom2 [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural instruction memory mux: combinational read, byte address.
  always_comb begin
    imem_instr = imem_sel ? rom2[imem_addr[11:2]] : rom1[imem_addr[11:2]];
  end

  fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bank_switch    (bank_switch),
    .bank_req       (bank_req),
    .imem_addr      (imem_addr),
    .imem_sel       (imem_sel),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .bank_busy      (bank_busy),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fault          (fault)
  );

  // Drive every input of the sequencer in one go.
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                               input logic bs, input logic br, input logic rdy);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bank_switch    = bs;
    bank_req       = br;
    out_ready      = rdy;
  endtask

  // One comparison: counts it and reports a failure with tag, observed, expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the decode-side output triple.
  task automatic checkOut(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc);
    checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      checkOutput({tag, ".instr"}, out_instr, instr);
      checkOutput({tag, ".pc"}, out_pc, pc);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom1[i] = 32'hA000_0000 + i;
      rom2[i] = 32'hB000_0000 + i;
    end

    // Reset values.
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    #2;
    checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst.instr", out_instr, 32'd0);
    checkOutput("rst.pc", out_pc, 32'd0);
    checkOutput("rst.addr", imem_addr, 32'd0);
    checkOutput("rst.sel", {31'd0, imem_sel}, 32'd0);
    checkOutput("rst.fault", {31'd0, fault}, 32'd0);
    checkOutput("rst.busy", {31'd0, bank_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential stream A,B,C,D with 1-cycle latency and back-pressure on B.
    tick(); checkOut("seq0", 1, 32'hA000_0000, 32'h0);
    tick(); checkOut("seq1", 1, 32'hA000_0001, 32'h4);
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOut("hold", 1, 32'hA000_0001, 32'h4);
      checkOutput("hold.addr", imem_addr, 32'h8);
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    tick(); checkOut("seq2", 1, 32'hA000_0002, 32'h8);
    tick(); checkOut("seq3", 1, 32'hA000_0003, 32'hC);
    checkOutput("seq3.addr", imem_addr, 32'h10);

    // Redirect to 0x4, then squash the unaccepted 0x4 word with a redirect to 0x40.
    applyStimulus(0, 1, 32'h4, 0, 0, 1);
    tick(); checkOut("redir4", 0, 32'h0, 32'h0);
    checkOutput("redir4.addr", imem_addr, 32'h4);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    tick(); checkOut("at4", 1, 32'hA000_0001, 32'h4);
    applyStimulus(0, 1, 32'h40, 0, 0, 0);
    tick(); checkOut("squash", 0, 32'h0, 32'h0);
    checkOutput("squash.addr", imem_addr, 32'h40);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    tick(); checkOut("at40", 1, 32'hA000_0010, 32'h40);

    // Stall: the held word is still accepted, PC is frozen.
    applyStimulus(1, 0, 32'h0, 0, 0, 1);
    tick(); checkOut("stall", 0, 32'h0, 32'h0);
    checkOutput("stall.addr", imem_addr, 32'h44);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    tick(); checkOut("at44", 1, 32'hA000_0011, 32'h44);

    // Bank switch to rom2 with a pending word; a redirect during DRAIN is ignored.
    applyStimulus(0, 0, 32'h0, 1, 1, 0);
    tick();
    checkOutput("drain.busy", {31'd0, bank_busy}, 32'd1);
    checkOutput("drain.sel", {31'd0, imem_sel}, 32'd0);
    checkOut("drain", 1, 32'hA000_0011, 32'h44);
    applyStimulus(0, 1, 32'h80, 0, 0, 0);
    tick();
    checkOutput("drainRedir.addr", imem_addr, 32'h48);
    checkOutput("drainRedir.sel", {31'd0, imem_sel}, 32'd0);
    checkOut("drainRedir", 1, 32'hA000_0011, 32'h44);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    tick();
    checkOut("drained", 0, 32'h0, 32'h0);
    checkOutput("drained.busy", {31'd0, bank_busy}, 32'd1);
    tick();
    checkOutput("switch.busy", {31'd0, bank_busy}, 32'd1);
    checkOutput("switch.sel", {31'd0, imem_sel}, 32'd0);
    tick();
    checkOutput("newbank.sel", {31'd0, imem_sel}, 32'd1);
    checkOutput("newbank.addr", imem_addr, 32'h0);
    checkOutput("newbank.busy", {31'd0, bank_busy}, 32'd0);
    checkOut("newbank", 0, 32'h0, 32'h0);
    tick(); checkOut("rom2w0", 1, 32'hB000_0000, 32'h0);

    // Switch request to the bank already selected is ignored.
    applyStimulus(0, 0, 32'h0, 1, 1, 1);
    tick();
    checkOut("samebank", 1, 32'hB000_0001, 32'h4);
    checkOutput("samebank.busy", {31'd0, bank_busy}, 32'd0);

    // Last-word boundary: 0xFF8, 0xFFC delivered, then fault with no wrap.
    applyStimulus(0, 1, 32'hFF8, 0, 0, 1);
    tick(); checkOut("toEnd", 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    tick();
    checkOut("endm1", 1, 32'hB000_03FE, 32'hFF8);
    checkOutput("endm1.fault", {31'd0, fault}, 32'd0);
    tick();
    checkOut("end", 1, 32'hB000_03FF, 32'hFFC);
    checkOutput("end.fault", {31'd0, fault}, 32'd1);
    tick();
    checkOut("postEnd", 0, 32'h0, 32'h0);
    checkOutput("postEnd.addr", imem_addr, 32'hFFC);
    tick();
    checkOut("postEnd2", 0, 32'h0, 32'h0);
    checkOutput("postEnd2.fault", {31'd0, fault}, 32'd1);

    // Asynchronous reset mid-cycle clears the fault and restarts.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.fault", {31'd0, fault}, 32'd0);
    checkOutput("arst.sel", {31'd0, imem_sel}, 32'd0);
    checkOutput("arst.addr", imem_addr, 32'd0);
    checkOutput("arst.valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); checkOut("restart", 1, 32'hA000_0000, 32'h0);

    // Misaligned redirect: sticky fault, no further output, bank switch ignored.
    applyStimulus(0, 1, 32'h42, 0, 0, 1);
    tick();
    checkOutput("mis.fault", {31'd0, fault}, 32'd1);
    checkOut("mis", 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 1);
    tick();
    checkOutput("mis.sel", {31'd0, imem_sel}, 32'd0);
    checkOutput("mis.busy", {31'd0, bank_busy}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("misHold.fault", {31'd0, fault}, 32'd1);
      checkOut("misHold", 0, 32'h0, 32'h0);
    end

    // Out-of-range redirect straight after reset.
    rst_n = 1'b0;
    #2;
    checkOutput("rst2.fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 32'h1000, 0, 0, 1);
    tick();
    checkOutput("oor.fault", {31'd0, fault}, 32'd1);
    checkOut("oor", 0, 32'h0, 32'h0);
    checkOutput("oor.addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
